// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback scheduler sharing the register file write ports among FU requesters.
// Optional conflict counter enabled by defining REGFILE_WB_ARB_PERF_EN.
module regfile_wb_arbiter #(
  parameter int NR_REQ         = 4,
  parameter int NR_WRITE_PORTS = 2,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NR_REQ-1:0]                          req_valid_i,
  input  logic [NR_REQ-1:0][4:0]                     req_addr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]          req_data_i,
  output logic [NR_REQ-1:0]                          req_ready_o,
  output logic [NR_WRITE_PORTS-1:0][4:0]             waddr_o,
  output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_o,
  output logic [NR_WRITE_PORTS-1:0]                  we_o
`ifdef REGFILE_WB_ARB_PERF_EN
  ,
  output logic [31:0]                                conflict_cnt_o
`endif
);

  localparam int PTR_W = $clog2(NR_REQ);
  localparam int CNT_W = $clog2(NR_WRITE_PORTS + 1);

  logic [PTR_W-1:0]                       rr_ptr_q;
  logic [PTR_W-1:0]                       rr_ptr_d;
  logic [PTR_W-1:0]                       last_idx;
  logic [PTR_W-1:0]                       idx;
  logic [PTR_W:0]                         sum;
  logic [CNT_W-1:0]                       n_grants;
  logic [NR_REQ-1:0]                      grant;
  logic [NR_WRITE_PORTS-1:0]              port_used;
  logic [NR_WRITE_PORTS-1:0][4:0]         port_addr;
  logic [NR_WRITE_PORTS-1:0][PTR_W-1:0]   port_src;
  logic                                   collide;

  // Circular scan from rr_ptr_q; each grant claims the next free port and blocks its address.
  always_comb begin
    grant     = '0;
    port_used = '0;
    port_addr = '0;
    port_src  = '0;
    n_grants  = '0;
    last_idx  = rr_ptr_q;
    idx       = '0;
    sum       = '0;
    collide   = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NR_REQ)) begin
        sum = sum - (PTR_W+1)'(NR_REQ);
      end
      idx     = sum[PTR_W-1:0];
      collide = 1'b0;
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
        if (port_used[p] && (port_addr[p] == req_addr_i[idx])) begin
          collide = 1'b1;
        end
      end
      if (req_valid_i[idx] && (n_grants < CNT_W'(NR_WRITE_PORTS)) && !collide) begin
        grant[idx] = 1'b1;
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
          if (n_grants == CNT_W'(p)) begin
            port_used[p] = 1'b1;
            port_addr[p] = req_addr_i[idx];
            port_src[p]  = idx;
          end
        end
        n_grants = n_grants + CNT_W'(1);
        last_idx = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant) begin
      rr_ptr_d = (last_idx == PTR_W'(NR_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
    end
  end

  assign req_ready_o = rst_i ? '0 : grant;

  // x0 grants occupy a port but never raise we, so they retire silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_o     <= '0;
      waddr_o  <= '0;
      wdata_o  <= '0;
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
        we_o[p] <= port_used[p] && (port_addr[p] != 5'd0);
        if (port_used[p]) begin
          waddr_o[p] <= port_addr[p];
          wdata_o[p] <= req_data_i[port_src[p]];
        end
      end
    end
  end

`ifdef REGFILE_WB_ARB_PERF_EN
  logic any_stall;

  assign any_stall = |(req_valid_i & ~grant);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
    end else if (any_stall && (conflict_cnt_o != 32'hFFFF_FFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: driver pushes model expectations, negedge monitor compares.
// Counter checks are compiled in when REGFILE_WB_ARB_PERF_EN is defined.
module tb_regfile_wb_arbiter;

  localparam int NR_REQ       = 4;
  localparam int NP           = 2;
  localparam int DW           = 32;
  localparam int STARVE_BOUND = (NR_REQ + NP - 1) / NP + 1;

  logic                          clk_i = 1'b0;
  logic                          rst_i = 1'b1;
  logic [NR_REQ-1:0]             req_valid_i;
  logic [NR_REQ-1:0][4:0]        req_addr_i;
  logic [NR_REQ-1:0][DW-1:0]     req_data_i;
  logic [NR_REQ-1:0]             req_ready_o;
  logic [NP-1:0][4:0]            waddr_o;
  logic [NP-1:0][DW-1:0]         wdata_o;
  logic [NP-1:0]                 we_o;
`ifdef REGFILE_WB_ARB_PERF_EN
  logic [31:0]                   conflict_cnt_o;
`endif

  typedef struct packed {
    logic [NP-1:0]          we;
    logic [NP-1:0][4:0]     addr;
    logic [NP-1:0][DW-1:0]  data;
    logic [31:0]            cnt;
  } wr_item_t;

  wr_item_t           wr_q[$];
  logic [NR_REQ-1:0]  rdy_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [NR_REQ-1:0]  rq_valid = '0;
  logic [4:0]         rq_addr[NR_REQ];
  logic [DW-1:0]      rq_data[NR_REQ];
  logic [NR_REQ-1:0]  last_ready = '0;

  int        m_ptr = 0;
  wr_item_t  m_state = '0;
  bit        starve_chk = 1'b0;
  int        wait_cyc[NR_REQ];
  logic [DW-1:0] rf[32];

  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter #(
    .NR_REQ(NR_REQ),
    .NR_WRITE_PORTS(NP),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .waddr_o(waddr_o),
    .wdata_o(wdata_o),
    .we_o(we_o)
`ifdef REGFILE_WB_ARB_PERF_EN
    ,
    .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic newReq(input int q, input logic [4:0] a, input logic [DW-1:0] d);
    rq_valid[q] = 1'b1;
    rq_addr[q]  = a;
    rq_data[q]  = d;
  endtask

  // Register file image built from what the DUT actually writes.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int p = 0; p < NP; p++) begin
        if (we_o[p] === 1'b1) rf[waddr_o[p]] <= wdata_o[p];
      end
    end
  end

  always @(negedge clk_i) begin
    wr_item_t ew;
    if (rdy_q.size() > 0) checkOutput("ready", 128'(req_ready_o), 128'(rdy_q.pop_front()));
    if (wr_q.size() > 0) begin
      ew = wr_q.pop_front();
      checkOutput("we", 128'(we_o), 128'(ew.we));
      checkOutput("waddr", 128'(waddr_o), 128'(ew.addr));
      checkOutput("wdata", 128'(wdata_o), 128'(ew.data));
`ifdef REGFILE_WB_ARB_PERF_EN
      checkOutput("conflict_cnt", 128'(conflict_cnt_o), 128'(ew.cnt));
`endif
    end
    if (starve_chk && !rst_i) begin
      for (int r = 0; r < NR_REQ; r++) begin
        if (req_valid_i[r]) begin
          if (req_ready_o[r]) begin
            checkOutput("starve_wait_over_bound", 128'(wait_cyc[r] + 1 > STARVE_BOUND), 128'(0));
            wait_cyc[r] = 0;
          end else begin
            wait_cyc[r]++;
          end
        end
      end
    end
  end

  // One call per cycle run: refresh requesters, drive, predict, then sample the handshake.
  task automatic applyStimulus(input bit do_rst, input int n_cycles, input int mode);
    logic [NR_REQ-1:0] exp_rdy;
    bit [31:0]         taken;
    int                ng;
    int                last;
    int                r;
    for (int c = 0; c < n_cycles; c++) begin
      @(posedge clk_i);
      #1;
      for (int q = 0; q < NR_REQ; q++) begin
        if (rq_valid[q] && last_ready[q]) rq_valid[q] = 1'b0;
        if (!rq_valid[q]) begin
          case (mode)
            0: if ($urandom_range(0, 1) == 1) newReq(q, 5'($urandom_range(0, 7)), $urandom);
            1: newReq(q, 5'(q + 1), $urandom);
            4: if (q < 3) newReq(q, 5'(q + 1), $urandom);
            default: ;
          endcase
        end
      end
      rst_i       = do_rst;
      req_valid_i = rq_valid;
      for (int q = 0; q < NR_REQ; q++) begin
        req_addr_i[q] = rq_addr[q];
        req_data_i[q] = rq_data[q];
      end

      exp_rdy = '0;
      if (do_rst) begin
        m_ptr   = 0;
        m_state = '0;
      end else begin
        taken = '0;
        ng    = 0;
        last  = -1;
        for (int k = 0; k < NR_REQ; k++) begin
          r = (m_ptr + k) % NR_REQ;
          if (rq_valid[r] && ng < NP && !taken[rq_addr[r]]) begin
            exp_rdy[r]          = 1'b1;
            taken[rq_addr[r]]   = 1'b1;
            m_state.addr[ng]    = rq_addr[r];
            m_state.data[ng]    = rq_data[r];
            m_state.we[ng]      = (rq_addr[r] != 5'd0);
            ng++;
            last = r;
          end
        end
        for (int p = ng; p < NP; p++) m_state.we[p] = 1'b0;
        if (last >= 0) m_ptr = (last + 1) % NR_REQ;
        if (((rq_valid & ~exp_rdy) != '0) && (m_state.cnt != 32'hFFFF_FFFF))
          m_state.cnt = m_state.cnt + 32'd1;
      end
      rdy_q.push_back(exp_rdy);
      wr_q.push_back(m_state);

      @(negedge clk_i);
      last_ready = req_ready_o;
    end
  endtask

  initial begin
    req_valid_i = '0;
    req_addr_i  = '0;
    req_data_i  = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int q = 0; q < NR_REQ; q++) begin
      rq_addr[q]  = '0;
      rq_data[q]  = '0;
      wait_cyc[q] = 0;
    end
    wr_q.push_back('0);

    $display("[TB] reset with all requesters valid, then round-robin");
    applyStimulus(1'b1, 2, 1);
    starve_chk = 1'b1;
    applyStimulus(1'b0, 8, 1);
    starve_chk = 1'b0;
    applyStimulus(1'b0, 4, 2);

    $display("[TB] address collision");
    applyStimulus(1'b1, 1, 2);
    newReq(0, 5'd5, 32'hAAAA_0001);
    newReq(1, 5'd5, 32'hBBBB_0002);
    newReq(2, 5'd6, 32'hCCCC_0003);
    applyStimulus(1'b0, 4, 2);
    checkOutput("x5_final", 128'(rf[5]), 128'(32'hBBBB_0002));
    checkOutput("x6_final", 128'(rf[6]), 128'(32'hCCCC_0003));

    $display("[TB] x0 request");
    newReq(1, 5'd0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3, 2);
    checkOutput("x0_after_x0_req", 128'(rf[0]), 128'(0));

    $display("[TB] sustained port shortage");
    applyStimulus(1'b1, 1, 2);
    applyStimulus(1'b0, 10, 4);
    applyStimulus(1'b1, 1, 2);
    applyStimulus(1'b0, 4, 2);

    $display("[TB] random traffic with mid-stream reset");
    applyStimulus(1'b0, 150, 0);
    applyStimulus(1'b1, 1, 0);
    applyStimulus(1'b0, 150, 0);
    applyStimulus(1'b0, 6, 2);
    checkOutput("x0_final", 128'(rf[0]), 128'(0));

    @(posedge clk_i);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
